// File: rtl/ram_pkg.sv
// Shared constants and FSM state encoding for the RAM burst controller
// and the single-port RAM it drives.
package ram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W      = 8;
    localparam int CNT_W      = LEN_W + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD       = 3'd2,
        RD_DRAIN = 3'd3,
        DONE     = 3'd4
    } state_e;

    // A length field of zero stands for the largest burst, 2^LEN_W bytes.
    function automatic logic [CNT_W-1:0] burst_bytes(input logic [LEN_W-1:0] len);
        return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    endfunction

endpackage

// File: rtl/bus_driver.sv
// Tristate driver for a shared bidirectional bus; releases the bus to
// high-Z whenever en is low.
module bus_driver #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] din,
    inout  wire  [W-1:0] bus
);

    assign bus = en ? din : {W{1'bz}};

endmodule

// File: rtl/sync_ram.sv
// Synchronous single-port RAM with a shared data bus: writes on the clock
// edge, reads register the word and present it on the bus the next cycle.
module sync_ram
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    inout  wire  [DATA_W-1:0] data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] dout_q;
    logic              oe_q;

    always_ff @(posedge clock) begin
        oe_q <= cs & read & ~write;
        if (cs & write) begin
            mem[addr] <= data;
        end else if (cs & read) begin
            dout_q <= mem[addr];
        end
    end

    // Never fight a write cycle from the controller on the shared bus.
    bus_driver #(.W(DATA_W)) u_drv (
        .en  (oe_q & ~write),
        .din (dout_q),
        .bus (data)
    );

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a synchronous single-port RAM: streams len bytes in
// from wr_data or out to rd_data starting at base_addr, wrapping the address.
module ram_burst_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic              cs,
    output logic              read,
    output logic              write,
    inout  wire  [DATA_W-1:0] data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              read_q, read_d;
    logic              wr_ready_q, wr_ready_d;
    logic              last_byte;

    assign last_byte = (cnt_q + CNT_W'(1) == len_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = burst_bytes(len);
                    cnt_d   = '0;
                    state_d = rw ? WR : RD;
                end
            end
            WR: begin
                if (wr_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_byte) begin
                        state_d = DONE;
                    end
                end
            end
            RD: begin
                // The RAM answers one cycle late, so the first RD cycle has nothing to sample.
                if (cnt_q != '0) begin
                    rd_data_d  = data;
                    rd_valid_d = 1'b1;
                end
                if (last_byte) begin
                    state_d = RD_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_DRAIN: begin
                rd_data_d  = data;
                rd_valid_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        cs_d       = (state_d inside {WR, RD, RD_DRAIN});
        read_d     = (state_d inside {RD, RD_DRAIN});
        wr_ready_d = (state_d == WR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= 1'b0;
            read_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
            read_q     <= read_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign addr     = base_q + ADDR_W'(cnt_q);
    assign wr_ready = wr_ready_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cs       = cs_q;
    assign read     = read_q;
    assign write    = wr_ready_q & wr_valid;

    bus_driver #(.W(DATA_W)) u_bus_driver (
        .en  (write),
        .din (wr_data),
        .bus (data)
    );

endmodule
